// File: rtl/tc_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : tc_timer_if
//  Description : CPU-bridge bus bundle for one timer/counter instance.
//                Carries word address, write strobe, write data, read data
//                and the interrupt request.
//  Revision    : 1.0  initial release
// ============================================================================
interface tc_timer_if;
   logic [29:0] Addr;   // word address Addr[31:2]
   logic        WE;     // window-qualified write enable
   logic [31:0] Din;    // write data
   logic [31:0] Dout;   // combinational read data
   logic        IRQ;    // interrupt request to CP0

   // Bridge side: drives the access, receives read data and interrupt.
   modport master (
      output Addr,
      output WE,
      output Din,
      input  Dout,
      input  IRQ
   );

   // Timer side: receives the access, returns read data and interrupt.
   modport slave (
      input  Addr,
      input  WE,
      input  Din,
      output Dout,
      output IRQ
   );
endinterface
`default_nettype wire

// File: rtl/tc_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tc_timer
//  Description : Memory-mapped 32-bit programmable timer/counter with one-shot
//                and auto-reload periodic countdown modes and a maskable
//                interrupt. Registers: CTRL, PRESET, COUNT (read-only).
//  Revision    : 1.0  initial release
// ============================================================================
module tc_timer (
   input  logic         clk,
   input  logic         reset,
   tc_timer_if.slave    bus
);

   // Register-select codes decoded from Addr[3:2].
   localparam logic [1:0] SEL_CTRL   = 2'd0;
   localparam logic [1:0] SEL_PRESET = 2'd1;
   localparam logic [1:0] SEL_COUNT  = 2'd2;

   // Mode field value that selects auto-reload; all others act as one-shot.
   localparam logic [1:0] MODE_PERIODIC = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_t;

   state_t      state;
   logic [3:0]  ctrl;       // {IM, Mode[1:0], Enable}
   logic [31:0] preset;
   logic [31:0] count;
   logic        irq_flag;

   logic [1:0]  sel;
   logic        enable;
   logic [1:0]  mode;
   logic        irq_mask;
   logic        unused_addr;

   assign sel      = bus.Addr[1:0];
   assign enable   = ctrl[0];
   assign mode     = ctrl[2:1];
   assign irq_mask = ctrl[3];

   // Only Addr[3:2] is decoded; the bridge has already qualified the window.
   assign unused_addr = ^bus.Addr[29:2];

   // Countdown FSM plus register writes; a bus write is applied after the
   // FSM update so a CTRL write overrides the FSM's Enable clear and its
   // irq_flag set on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         ctrl     <= 4'd0;
         preset   <= 32'd0;
         count    <= 32'd0;
         irq_flag <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (enable) begin
                  state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               count <= preset;
               state <= ST_CNT;
            end
            ST_CNT: begin
               if (!enable) begin
                  // Paused: COUNT is held for inspection and reload on resume.
                  state <= ST_IDLE;
               end else if (count > 32'd1) begin
                  count <= count - 32'd1;
               end else begin
                  // Terminal step also covers PRESET=0, so COUNT never wraps.
                  count    <= 32'd0;
                  irq_flag <= 1'b1;
                  state    <= ST_INT;
               end
            end
            ST_INT: begin
               if (mode == MODE_PERIODIC) begin
                  // Single-cycle pulse; Enable stays set so the next period
                  // starts from IDLE automatically.
                  irq_flag <= 1'b0;
               end else begin
                  // One-shot: stop the timer, keep the flag until software
                  // acknowledges it with a CTRL write.
                  ctrl[0] <= 1'b0;
               end
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase

         if (bus.WE) begin
            case (sel)
               SEL_CTRL: begin
                  ctrl     <= bus.Din[3:0];
                  irq_flag <= 1'b0;
               end
               SEL_PRESET: begin
                  preset <= bus.Din;
               end
               default: begin
                  // COUNT and the reserved slot ignore writes.
               end
            endcase
         end
      end
   end

   // Zero-latency read mux back to the bridge.
   always_comb begin
      bus.Dout = 32'd0;
      case (sel)
         SEL_CTRL:   bus.Dout = {28'd0, ctrl};
         SEL_PRESET: bus.Dout = preset;
         SEL_COUNT:  bus.Dout = count;
         default:    bus.Dout = 32'd0;
      endcase
   end

   assign bus.IRQ = irq_mask & irq_flag;

endmodule
`default_nettype wire

// File: tb/tb_tc_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tc_timer
//  Description : Self-checking bench for tc_timer. A reference model of the
//                timer's register/period rules runs alongside the DUT and is
//                compared every cycle; directed scenarios add hand-computed
//                literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tc_timer;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   tc_timer_if bus ();

   tc_timer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------
   // Reference model: timer phase (waiting / arming / counting / expired)
   // and the programmer-visible registers, advanced once per clock edge.
   // ---------------------------------------------------------------------
   localparam int PH_WAIT   = 0;
   localparam int PH_ARM    = 1;
   localparam int PH_COUNT  = 2;
   localparam int PH_EXPIRE = 3;

   typedef struct packed {
      logic [3:0]  ctrl;
      logic [31:0] preset;
      logic [31:0] count;
      logic        flag;
      int          phase;
   } mstate_t;

   mstate_t m;
   bit      m_valid = 1'b0;

   function automatic mstate_t model_step(mstate_t s, logic we,
                                          logic [1:0] a, logic [31:0] d);
      mstate_t n = s;
      if (s.phase == PH_WAIT) begin
         if (s.ctrl[0]) n.phase = PH_ARM;
      end else if (s.phase == PH_ARM) begin
         n.count = s.preset;
         n.phase = PH_COUNT;
      end else if (s.phase == PH_COUNT) begin
         if (!s.ctrl[0]) begin
            n.phase = PH_WAIT;
         end else if (s.count >= 32'd2) begin
            n.count = s.count - 32'd1;
         end else begin
            n.count = 32'd0;
            n.flag  = 1'b1;
            n.phase = PH_EXPIRE;
         end
      end else begin
         if (s.ctrl[2:1] == 2'b01) n.flag = 1'b0;
         else                      n.ctrl[0] = 1'b0;
         n.phase = PH_WAIT;
      end
      if (we && a == 2'd0) begin
         n.ctrl = d[3:0];
         n.flag = 1'b0;
      end
      if (we && a == 2'd1) n.preset = d;
      return n;
   endfunction

   function automatic logic [31:0] model_read(mstate_t s, logic [1:0] a);
      case (a)
         2'd0:    return {28'd0, s.ctrl};
         2'd1:    return s.preset;
         2'd2:    return s.count;
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m       <= '0;
         m_valid <= 1'b1;
      end else begin
         m <= model_step(m, bus.WE, bus.Addr[1:0], bus.Din);
      end
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (m_valid) begin
         check("model_dout", bus.Dout, model_read(m, bus.Addr[1:0]));
         check("model_irq", {31'd0, bus.IRQ}, {31'd0, m.ctrl[3] & m.flag});
      end
   end

   // ---------------------------------------------------------------------
   // Stimulus helpers: inputs change 1 time unit after each rising edge.
   // ---------------------------------------------------------------------
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus.Addr = {28'd0, a};
      bus.WE   = 1'b1;
      bus.Din  = d;
      cyc(1);
      bus.WE   = 1'b0;
      bus.Din  = 32'd0;
   endtask

   task automatic peek(input string name, input logic [1:0] a,
                       input logic [31:0] exp);
      bus.Addr = {28'd0, a};
      #1;
      check(name, bus.Dout, exp);
   endtask

   task automatic peek_irq(input string name, input logic exp);
      #1;
      check(name, {31'd0, bus.IRQ}, {31'd0, exp});
   endtask

   int pulses;

   initial begin
      #100000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      checks   = 0;
      errors   = 0;
      reset    = 1'b1;
      bus.Addr = 30'd0;
      bus.WE   = 1'b0;
      bus.Din  = 32'd0;
      cyc(2);
      reset = 1'b0;

      // Reset state
      peek("rst_ctrl",   2'd0, 32'd0);
      peek("rst_preset", 2'd1, 32'd0);
      peek("rst_count",  2'd2, 32'd0);
      peek("rst_rsvd",   2'd3, 32'd0);
      peek_irq("rst_irq", 1'b0);

      // One-shot, PRESET=3
      wr(2'd1, 32'd3);
      peek("os_preset", 2'd1, 32'd3);
      wr(2'd0, 32'h9);
      cyc(2);
      peek("os_count3", 2'd2, 32'd3);
      cyc(1); peek("os_count2", 2'd2, 32'd2);
      cyc(1); peek("os_count1", 2'd2, 32'd1);
      peek_irq("os_irq_low", 1'b0);
      cyc(1); peek("os_count0", 2'd2, 32'd0);
      peek_irq("os_irq_rise", 1'b1);
      cyc(1); peek("os_ctrl_after", 2'd0, 32'h8);
      cyc(3); peek_irq("os_irq_held", 1'b1);
      peek("os_count_held", 2'd2, 32'd0);
      wr(2'd0, 32'h8);
      peek_irq("os_irq_ack", 1'b0);

      // Periodic, PRESET=2: pulse every 5 cycles
      wr(2'd1, 32'd2);
      wr(2'd0, 32'hB);
      pulses = 0;
      bus.Addr = 30'd2;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         #1;
         if (bus.IRQ) pulses++;
      end
      check("per_pulses", pulses, 32'd4);
      wr(2'd0, 32'h0);
      cyc(3);
      peek_irq("per_stopped_irq", 1'b0);

      // Masked interrupt, PRESET=2
      wr(2'd1, 32'd2);
      wr(2'd0, 32'h1);
      cyc(5);
      peek("mask_ctrl", 2'd0, 32'h0);
      peek("mask_count", 2'd2, 32'd0);
      peek_irq("mask_irq", 1'b0);

      // Pause and resume, PRESET=10
      wr(2'd1, 32'd10);
      wr(2'd0, 32'h9);
      cyc(5);
      peek("pr_count7", 2'd2, 32'd7);
      wr(2'd0, 32'h8);
      cyc(1);
      peek("pr_frozen", 2'd2, 32'd6);
      cyc(3);
      peek("pr_still", 2'd2, 32'd6);
      wr(2'd0, 32'h9);
      cyc(2);
      peek("pr_reload", 2'd2, 32'd10);
      wr(2'd0, 32'h0);
      cyc(2);

      // PRESET=0 expires after one counting cycle
      wr(2'd1, 32'd0);
      wr(2'd0, 32'h9);
      cyc(2);
      peek("z_count", 2'd2, 32'd0);
      peek_irq("z_irq_low", 1'b0);
      cyc(1);
      peek_irq("z_irq", 1'b1);
      wr(2'd0, 32'h8);
      cyc(1);

      // COUNT and reserved slot ignore writes
      wr(2'd2, 32'h55);
      peek("wr_count_ign", 2'd2, 32'd0);
      wr(2'd3, 32'hFFFF_FFFF);
      peek("wr_rsvd_ign", 2'd3, 32'd0);
      peek("wr_ctrl_kept", 2'd0, 32'h8);

      // Enable dropped during LOAD: LOAD completes, then exits to IDLE
      wr(2'd1, 32'd4);
      wr(2'd0, 32'h9);
      wr(2'd0, 32'h8);
      cyc(2);
      peek("ld_count", 2'd2, 32'd4);
      cyc(2);
      peek("ld_hold", 2'd2, 32'd4);

      // Reset mid-count at COUNT=5
      wr(2'd1, 32'd10);
      wr(2'd0, 32'h9);
      cyc(7);
      peek("mr_count5", 2'd2, 32'd5);
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      peek("mr_ctrl",   2'd0, 32'd0);
      peek("mr_preset", 2'd1, 32'd0);
      peek("mr_count",  2'd2, 32'd0);
      peek_irq("mr_irq", 1'b0);
      cyc(4);
      peek("mr_idle", 2'd2, 32'd0);

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/tc_timer.md
Name: tc_timer

Overview:
- Memory-mapped programmable timer/counter. Sits directly downstream of the CPU system bridge.
- The bridge decodes the timer's address window and drives the write enable. It muxes this block's read data back to the CPU.
- Two instances exist, TC1 and TC2. Each IRQ output feeds an external-interrupt line of CP0.
- Supports one-shot countdown (mode 0) and auto-reload periodic countdown (mode 1).

Parameters:
- None. Register width is fixed at 32 bits.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- Addr  input  30  word address Addr[31:2]; only Addr[3:2] is decoded by this block
- WE  input  1  write enable from the bridge, already window-qualified
- Din  input  32  write data
- Dout  output  32  combinational read data for Addr
- IRQ  output  1  interrupt request, level as defined below

Behaviour:
- Register map, selected by Addr[3:2]:
  - 0: CTRL. Bit 3 = IM (interrupt mask), bits 2:1 = Mode, bit 0 = Enable. Bits 31:4 read 0.
  - 1: PRESET, read/write.
  - 2: COUNT, read-only; writes are ignored.
  - 3: reads 0; writes are ignored.
- Reads: Dout = selected register, purely combinational, zero latency.
- Writes: take effect at the clk edge with WE=1.
  - CTRL stores Din[3:0].
  - Any CTRL write also clears irq_flag at that edge.
- Reset (synchronous, any state, including mid-count):
  - CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE.
  - Therefore IRQ=0 and Dout=0 for every address.
- IRQ = CTRL.IM & irq_flag.
- FSM: states IDLE, LOAD, CNT, INT. Transitions are evaluated on every edge without reset.
  - IDLE: if Enable=1, go to LOAD. Otherwise stay.
  - LOAD: COUNT <= PRESET, go to CNT.
  - CNT:
    - Enable=0: go to IDLE; COUNT holds its value.
    - Enable=1 and COUNT>1: COUNT <= COUNT-1.
    - Enable=1 and COUNT<=1: COUNT <= 0, irq_flag <= 1, go to INT. PRESET=0 therefore behaves like PRESET=1.
  - INT:
    - Mode=00: Enable <= 0, go to IDLE; irq_flag holds until a CTRL write or reset.
    - Mode=01: irq_flag <= 0, go to IDLE. The IRQ pulse is exactly one cycle; the next period reloads automatically.
    - Mode=10/11: treated as mode 0.
- Period and timing:
  - Mode 1 period with PRESET=N (N>=1) is N+3 cycles: IDLE + LOAD + N×CNT + INT.
  - IRQ rises N+2 edges after the edge that sets Enable.
- Simultaneous events:
  - CTRL write on the same edge as the FSM's INT update: the written CTRL value wins over the FSM's Enable clear. The write also clears irq_flag, which wins over the CNT→INT set.
  - PRESET write during CNT does not disturb COUNT. The new value is used at the next LOAD.
  - Writing Enable=0 during LOAD: LOAD still completes, then CNT exits to IDLE on the next edge.
- Arithmetic:
  - 32-bit unsigned.
  - No decrement below 0; COUNT never wraps.

Test Plan:
- Reset/read: assert reset 1 cycle, then read Addr[3:2]=0,1,2,3 → Dout=0 each; IRQ=0.
- One-shot:
  - Write PRESET=3, then CTRL=0x9.
  - COUNT reads 3,2,1,0 on successive cycles after LOAD.
  - IRQ=1 from the edge COUNT hits 0 and stays high.
  - CTRL reads 0x8 after the INT cycle.
  - Writing CTRL=0x8 drops IRQ the next cycle.
- Periodic:
  - PRESET=2, CTRL=0xB.
  - IRQ is a 1-cycle pulse every 5 cycles; 4 pulses observed in 20 cycles; COUNT never below 0.
- Mask:
  - PRESET=2, CTRL=0x1.
  - Countdown completes; IRQ stays 0; CTRL becomes 0x0.
- Pause/resume:
  - PRESET=10, CTRL=0x9; after COUNT=7 write CTRL=0x8.
  - COUNT frozen at 6 (one more decrement on the write edge is allowed only if already in CNT that edge; the bench checks it is stable afterwards).
  - Re-enable → LOAD reloads 10.
- Edge cases:
  - PRESET=0 with Enable → IRQ after 1 CNT cycle.
  - Write COUNT=0x55 → COUNT unchanged.
  - Reset asserted while in CNT with COUNT=5 → all registers 0, IDLE, IRQ=0 next cycle.
